// File: rtl/multicycle_cpu_pkg.sv
// rtl/multicycle_cpu_pkg.sv - encodings, state/ALU enums and instruction classifier for multicycle_cpu
package multicycle_cpu_pkg;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB} state_e;
    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_MUL} alu_op_e;
    typedef enum logic [2:0] {K_REG, K_ADDI, K_LOAD, K_STORE, K_BEQ, K_ILLEGAL} insn_kind_e;

    typedef struct packed {
        insn_kind_e kind;
        alu_op_e    op;
    } decoded_t;

    // Anything not matched exactly stays K_ILLEGAL and executes as a NOP.
    function automatic decoded_t decode(input logic [31:0] ir);
        decoded_t d;
        d.kind = K_ILLEGAL;
        d.op   = ALU_ADD;
        case (ir[6:0])
            OP_REG: begin
                case ({ir[31:25], ir[14:12]})
                    {F7_BASE, F3_ADD}: begin d.kind = K_REG; d.op = ALU_ADD; end
                    {F7_ALT,  F3_ADD}: begin d.kind = K_REG; d.op = ALU_SUB; end
                    {F7_BASE, F3_AND}: begin d.kind = K_REG; d.op = ALU_AND; end
                    {F7_BASE, F3_OR}:  begin d.kind = K_REG; d.op = ALU_OR;  end
                    {F7_MUL,  F3_ADD}: begin d.kind = K_REG; d.op = ALU_MUL; end
                    default: ;
                endcase
            end
            OP_IMM:    if (ir[14:12] == F3_ADD) d.kind = K_ADDI;
            OP_LOAD:   if (ir[14:12] == F3_W)   d.kind = K_LOAD;
            OP_STORE:  if (ir[14:12] == F3_W)   d.kind = K_STORE;
            OP_BRANCH: if (ir[14:12] == F3_BEQ) d.kind = K_BEQ;
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/multicycle_cpu_regfile.sv
// rtl/multicycle_cpu_regfile.sv - NREG x XLEN register file, two async reads, one sync write, x0 tied to zero
module multicycle_cpu_regfile #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [$clog2(NREG)-1:0]  raddr1,
    input  logic [$clog2(NREG)-1:0]  raddr2,
    output logic [XLEN-1:0]          rdata1,
    output logic [XLEN-1:0]          rdata2,
    input  logic                     we,
    input  logic [$clog2(NREG)-1:0]  waddr,
    input  logic [XLEN-1:0]          wdata
);

    logic [XLEN-1:0] regs [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (we && waddr != '0) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/multicycle_cpu.sv
// rtl/multicycle_cpu.sv - multi-cycle RV32-subset core with handshaked instruction and data memory ports
module multicycle_cpu
    import multicycle_cpu_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              NREG     = 32,
    parameter logic [XLEN-1:0] PC_RESET = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ready_i,
    input  logic [31:0]     imem_rdata_i,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    input  logic            dmem_ready_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic            retire_o,
    output logic            illegal_o
);

    localparam int RW = $clog2(NREG);

    state_e          state, state_nxt, resume;
    logic [XLEN-1:0] pc, pc_plus4;
    logic [31:0]     ir;
    logic [XLEN-1:0] a_q, b_q, imm_q, alu_q, ld_q;
    logic [XLEN-1:0] imm, op_b, alu_out, wb_data;
    logic [XLEN-1:0] rf_rdata1, rf_rdata2;
    logic            rf_we;
    decoded_t        dec;

    assign dec      = decode(ir);
    assign pc_plus4 = pc + XLEN'(4);

    always_comb begin
        imm = {{(XLEN-12){ir[31]}}, ir[31:20]};
        case (ir[6:0])
            OP_STORE:  imm = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
            OP_BRANCH: imm = {{(XLEN-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            default: ;
        endcase
    end

    // addi/lw/sw use the immediate; beq compares the raw register pair instead.
    assign op_b = (dec.kind == K_REG) ? b_q : imm_q;

    always_comb begin
        alu_out = a_q + op_b;
        case (dec.op)
            ALU_SUB: alu_out = a_q - op_b;
            ALU_AND: alu_out = a_q & op_b;
            ALU_OR:  alu_out = a_q | op_b;
            ALU_MUL: alu_out = a_q * op_b;
            default: ;
        endcase
    end

    assign resume = start_i ? FETCH : IDLE;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (start_i) state_nxt = FETCH;
            FETCH:  if (imem_ready_i) state_nxt = DECODE;
            DECODE: state_nxt = EXEC;
            EXEC: begin
                case (dec.kind)
                    K_REG, K_ADDI:   state_nxt = WB;
                    K_LOAD, K_STORE: state_nxt = MEM;
                    default:         state_nxt = resume;
                endcase
            end
            MEM:    if (dmem_ready_i) state_nxt = (dec.kind == K_STORE) ? resume : WB;
            WB:     state_nxt = resume;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
            pc    <= PC_RESET;
            ir    <= '0;
            a_q   <= '0;
            b_q   <= '0;
            imm_q <= '0;
            alu_q <= '0;
            ld_q  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                FETCH: if (imem_ready_i) ir <= imem_rdata_i;
                DECODE: begin
                    a_q   <= rf_rdata1;
                    b_q   <= rf_rdata2;
                    imm_q <= imm;
                end
                EXEC: begin
                    alu_q <= alu_out;
                    if (dec.kind == K_BEQ)
                        pc <= (a_q == b_q) ? pc + imm_q : pc_plus4;
                    else if (dec.kind == K_ILLEGAL)
                        pc <= pc_plus4;
                end
                MEM: begin
                    if (dmem_ready_i) begin
                        ld_q <= dmem_rdata_i;
                        if (dec.kind == K_STORE) pc <= pc_plus4;
                    end
                end
                WB: pc <= pc_plus4;
                default: ;
            endcase
        end
    end

    assign rf_we   = (state == WB);
    assign wb_data = (dec.kind == K_LOAD) ? ld_q : alu_q;

    multicycle_cpu_regfile #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
        .clk    (clk_i),
        .rst_n  (rst_i),
        .raddr1 (ir[15 +: RW]),
        .raddr2 (ir[20 +: RW]),
        .rdata1 (rf_rdata1),
        .rdata2 (rf_rdata2),
        .we     (rf_we),
        .waddr  (ir[7 +: RW]),
        .wdata  (wb_data)
    );

    // Request buses come straight from registers, so they hold still across wait states.
    assign imem_req_o   = (state == FETCH);
    assign imem_addr_o  = pc;
    assign dmem_req_o   = (state == MEM);
    assign dmem_we_o    = dmem_req_o && (dec.kind == K_STORE);
    assign dmem_addr_o  = alu_q;
    assign dmem_wdata_o = b_q;

    assign retire_o  = (state == WB)
                    || (state == EXEC && dec.kind == K_BEQ)
                    || (state == MEM && dmem_ready_i && dec.kind == K_STORE);
    assign illegal_o = (state == EXEC) && (dec.kind == K_ILLEGAL);

endmodule

// File: tb/tb_multicycle_cpu.sv
// tb/tb_multicycle_cpu.sv - scoreboard bench for multicycle_cpu with wait-state memory models
module tb_multicycle_cpu;

    logic        clk = 1'b0;
    logic        rst_n, start;
    logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready;
    logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;
    logic        retire, illegal;
    logic        long_wait;

    always #5 clk = ~clk;

    multicycle_cpu dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .start_i      (start),
        .imem_req_o   (imem_req),
        .imem_addr_o  (imem_addr),
        .imem_ready_i (imem_ready),
        .imem_rdata_i (imem_rdata),
        .dmem_req_o   (dmem_req),
        .dmem_we_o    (dmem_we),
        .dmem_addr_o  (dmem_addr),
        .dmem_wdata_o (dmem_wdata),
        .dmem_ready_i (dmem_ready),
        .dmem_rdata_i (dmem_rdata),
        .retire_o     (retire),
        .illegal_o    (illegal)
    );

    logic [31:0] imem [64];
    logic [31:0] dmem [64];
    int iw_cnt = 0, dw_cnt = 0, imem_wait, dmem_wait;

    always_comb imem_wait = (imem_addr == 32'h30) ? 2 : 0;
    always_comb dmem_wait = dmem_we ? 0 : (long_wait ? 20 : 3);
    assign imem_ready = imem_req && (iw_cnt >= imem_wait);
    assign dmem_ready = dmem_req && (dw_cnt >= dmem_wait);
    assign imem_rdata = imem[imem_addr[7:2]];
    assign dmem_rdata = dmem[dmem_addr[7:2]];

    always @(posedge clk) begin
        iw_cnt <= (imem_req && !imem_ready) ? iw_cnt + 1 : 0;
        dw_cnt <= (dmem_req && !dmem_ready) ? dw_cnt + 1 : 0;
        if (dmem_req && dmem_ready && dmem_we) dmem[dmem_addr[7:2]] <= dmem_wdata;
    end

    typedef struct { logic [31:0] addr; int gap; int ret; int ill; } fetch_exp_t;
    typedef struct { logic we; logic [31:0] addr; logic [31:0] data; int reqc; } dmem_exp_t;
    fetch_exp_t fq[$];
    dmem_exp_t  dq[$];

    int errors = 0, checks = 0;
    int cyc = 0, last_fetch_cyc = 0, ret_cnt = 0, ill_cnt = 0, req_seen = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] r_op(input logic [6:0] f7, input logic [2:0] f3, input int rd, input int rs1, input int rs2);
        return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
    endfunction
    function automatic logic [31:0] i_op(input logic [6:0] op, input logic [2:0] f3, input int rd, input int rs1, input int imm);
        logic [11:0] i = 12'(imm);
        return {i, 5'(rs1), f3, 5'(rd), op};
    endfunction
    function automatic logic [31:0] s_op(input int rs2, input int rs1, input int imm);
        logic [11:0] i = 12'(imm);
        return {i[11:5], 5'(rs2), 5'(rs1), 3'b010, i[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] b_op(input int rs1, input int rs2, input int imm);
        logic [12:0] i = 13'(imm);
        return {i[12], i[10:5], 5'(rs2), 5'(rs1), 3'b000, i[4:1], i[11], 7'b1100011};
    endfunction

    task automatic put(input logic [31:0] addr, input logic [31:0] insn);
        imem[addr[7:2]] = insn;
    endtask
    task automatic exp_fetch(input logic [31:0] addr, input int gap, input int ret, input int ill);
        fetch_exp_t e;
        e.addr = addr; e.gap = gap; e.ret = ret; e.ill = ill;
        fq.push_back(e);
    endtask
    task automatic exp_dmem(input logic we, input logic [31:0] addr, input logic [31:0] data, input int reqc);
        dmem_exp_t e;
        e.we = we; e.addr = addr; e.data = data; e.reqc = reqc;
        dq.push_back(e);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    fetch_exp_t  fe;
    dmem_exp_t   de;
    int          d_cnt = 0;
    logic        d_stable = 1'b1;
    logic [31:0] d_addr0, d_wdata0;
    logic        d_we0;

    always @(negedge clk) begin
        if (!rst_n) begin
            d_cnt = 0;
            d_stable = 1'b1;
        end else begin
            if (retire)   ret_cnt++;
            if (illegal)  ill_cnt++;
            if (imem_req) req_seen++;
            if (imem_req && imem_ready && fq.size() != 0) begin
                fe = fq.pop_front();
                check("fetch_addr", 64'(imem_addr), 64'(fe.addr));
                check("fetch_gap", 64'(cyc - last_fetch_cyc), 64'(fe.gap));
                check("retire_count", 64'(ret_cnt), 64'(fe.ret));
                check("illegal_count", 64'(ill_cnt), 64'(fe.ill));
                last_fetch_cyc = cyc;
                ret_cnt = 0;
                ill_cnt = 0;
            end
            if (dmem_req) begin
                if (d_cnt == 0) begin
                    d_addr0 = dmem_addr; d_we0 = dmem_we; d_wdata0 = dmem_wdata;
                end else if (dmem_addr !== d_addr0 || dmem_we !== d_we0 || dmem_wdata !== d_wdata0) begin
                    d_stable = 1'b0;
                end
                d_cnt++;
                if (dmem_ready) begin
                    check("dmem_expected", 64'(dq.size() != 0), 64'd1);
                    if (dq.size() != 0) begin
                        de = dq.pop_front();
                        check("dmem_we", 64'(dmem_we), 64'(de.we));
                        check("dmem_addr", 64'(dmem_addr), 64'(de.addr));
                        if (de.we) check("dmem_wdata", 64'(dmem_wdata), 64'(de.data));
                        check("dmem_req_cycles", 64'(d_cnt), 64'(de.reqc));
                        check("dmem_stable", 64'(d_stable), 64'd1);
                    end
                    d_cnt = 0;
                    d_stable = 1'b1;
                end
            end
        end
    end

    task automatic load_program();
        put(32'h00, i_op(7'b0010011, 3'b000, 1, 0, 5));
        put(32'h04, i_op(7'b0010011, 3'b000, 2, 0, 7));
        put(32'h08, r_op(7'b0000000, 3'b000, 3, 1, 2));
        put(32'h0C, r_op(7'b0000001, 3'b000, 4, 3, 2));
        put(32'h10, s_op(4, 0, 0));
        put(32'h14, s_op(3, 0, 8));
        put(32'h18, b_op(6, 2, 16));
        put(32'h1C, i_op(7'b0010011, 3'b000, 6, 0, 7));
        put(32'h20, b_op(1, 1, -8));
        put(32'h24, 32'h0000007F);
        put(32'h28, i_op(7'b0000011, 3'b010, 5, 0, 8));
        put(32'h2C, s_op(5, 0, 12));
        put(32'h30, r_op(7'b0100000, 3'b000, 7, 5, 1));
        put(32'h34, r_op(7'b0000000, 3'b111, 8, 4, 3));
        put(32'h38, r_op(7'b0000000, 3'b110, 9, 4, 3));
        put(32'h3C, i_op(7'b0010011, 3'b000, 0, 0, 9));
        put(32'h40, s_op(0, 0, 4));
        put(32'h44, 32'h0000007F);
        put(32'h48, s_op(7, 0, 16));
        put(32'h4C, s_op(8, 0, 20));
        put(32'h50, s_op(9, 0, 24));
        put(32'h54, i_op(7'b0010011, 3'b000, 10, 0, -1));
        put(32'h58, s_op(10, 0, 28));
        put(32'h5C, b_op(0, 0, 0));

        exp_fetch(32'h00, 1, 0, 0); exp_fetch(32'h04, 4, 1, 0); exp_fetch(32'h08, 4, 1, 0);
        exp_fetch(32'h0C, 4, 1, 0); exp_fetch(32'h10, 4, 1, 0); exp_fetch(32'h14, 4, 1, 0);
        exp_fetch(32'h18, 4, 1, 0); exp_fetch(32'h1C, 3, 1, 0); exp_fetch(32'h20, 4, 1, 0);
        exp_fetch(32'h18, 3, 1, 0); exp_fetch(32'h28, 3, 1, 0); exp_fetch(32'h2C, 8, 1, 0);
        exp_fetch(32'h30, 6, 1, 0); exp_fetch(32'h34, 4, 1, 0); exp_fetch(32'h38, 4, 1, 0);
        exp_fetch(32'h3C, 4, 1, 0); exp_fetch(32'h40, 4, 1, 0); exp_fetch(32'h44, 4, 1, 0);
        exp_fetch(32'h48, 3, 0, 1); exp_fetch(32'h4C, 4, 1, 0); exp_fetch(32'h50, 4, 1, 0);
        exp_fetch(32'h54, 4, 1, 0); exp_fetch(32'h58, 4, 1, 0); exp_fetch(32'h5C, 4, 1, 0);
        exp_fetch(32'h5C, 3, 1, 0);

        exp_dmem(1'b1, 32'd0,  32'd84, 1);
        exp_dmem(1'b1, 32'd8,  32'd12, 1);
        exp_dmem(1'b0, 32'd8,  32'd0,  4);
        exp_dmem(1'b1, 32'd12, 32'd12, 1);
        exp_dmem(1'b1, 32'd4,  32'd0,  1);
        exp_dmem(1'b1, 32'd16, 32'd7,  1);
        exp_dmem(1'b1, 32'd20, 32'd4,  1);
        exp_dmem(1'b1, 32'd24, 32'd92, 1);
        exp_dmem(1'b1, 32'd28, 32'hFFFFFFFF, 1);
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while ((fq.size() != 0 || dq.size() != 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("drain_in_time", 64'(n < limit), 64'd1);
    endtask

    task automatic begin_run();
        start = 1'b1;
        last_fetch_cyc = cyc;
        ret_cnt = 0;
        ill_cnt = 0;
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        long_wait = 1'b0;
        load_program();
        repeat (2) @(negedge clk);
        check("rst_imem_req", 64'(imem_req), 64'd0);
        check("rst_imem_addr", 64'(imem_addr), 64'd0);
        check("rst_dmem_req", 64'(dmem_req), 64'd0);
        check("rst_dmem_we", 64'(dmem_we), 64'd0);
        check("rst_dmem_addr", 64'(dmem_addr), 64'd0);
        check("rst_dmem_wdata", 64'(dmem_wdata), 64'd0);
        check("rst_retire", 64'(retire), 64'd0);
        check("rst_illegal", 64'(illegal), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("no_req_without_start", 64'(req_seen), 64'd0);
        begin_run();
        wait_drain(600);

        start = 1'b0;
        rst_n = 1'b0;
        put(32'h00, i_op(7'b0000011, 3'b010, 1, 0, 8));
        long_wait = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        begin_run();
        exp_fetch(32'h00, 1, 0, 0);
        n = 0;
        while (!dmem_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("mem_wait_reached", 64'(dmem_req), 64'd1);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        start = 1'b0;
        #1;
        check("abort_dmem_req", 64'(dmem_req), 64'd0);
        check("abort_dmem_addr", 64'(dmem_addr), 64'd0);
        check("abort_imem_addr", 64'(imem_addr), 64'd0);
        check("abort_retire", 64'(retire), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_imem_req", 64'(imem_req), 64'd0);
        begin_run();
        exp_fetch(32'h00, 1, 0, 0);
        wait_drain(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
